// File: rtl/wb_arbiter_if.sv
// Bus bundle between the result producers (ALU, load unit) and the write-back arbiter.
// Handshake: a load transfers on a rising edge where ld_valid_i && ld_ready_o are
// both high; the ALU stream has valid only and is always accepted.
interface wb_arbiter_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          alu_valid_i;
  logic [4:0]    alu_rd_i;
  logic [31:0]   alu_data_i;
  logic          ld_valid_i;
  logic          ld_ready_o;
  logic [4:0]    ld_rd_i;
  logic [31:0]   ld_data_i;
  logic [4:0]    rsW_o;
  logic [31:0]   dataW_o;
  logic          RegWEn_o;
  logic [31:0]   pending_mask_o;
  logic [CW-1:0] count_o;

  // Producer side: drives results, observes the write port and status.
  modport master (
    output alu_valid_i, alu_rd_i, alu_data_i,
    output ld_valid_i, ld_rd_i, ld_data_i,
    input  ld_ready_o,
    input  rsW_o, dataW_o, RegWEn_o, pending_mask_o, count_o
  );

  // Arbiter side.
  modport slave (
    input  alu_valid_i, alu_rd_i, alu_data_i,
    input  ld_valid_i, ld_rd_i, ld_data_i,
    output ld_ready_o,
    output rsW_o, dataW_o, RegWEn_o, pending_mask_o, count_o
  );
endinterface

// File: rtl/wb_arbiter.sv
// Write-back arbiter: ALU results win the register-file write port every cycle;
// load returns wait in a small FIFO and drain when the ALU is silent. An ALU
// write kills any queued load to the same register so the younger value wins.
module wb_arbiter #(
  parameter int DEPTH = 4
) (
  input logic         clk_i,
  input logic         rst_i,
  wb_arbiter_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [4:0]    rd_q   [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [DEPTH-1:0] live_q;
  logic [PW-1:0] wptr_q;
  logic [PW-1:0] rptr_q;
  logic [CW-1:0] count_q;
  logic [4:0]    rs_q;
  logic [31:0]   wdata_q;
  logic          we_q;

  logic          alu_wr;
  logic          ld_ready;
  logic          push;
  logic          pop;
  logic          push_live;
  logic [31:0]   mask;

  // Decode this cycle's ALU write, load handshake, push and pop.
  always_comb begin
    alu_wr    = bus.alu_valid_i && (bus.alu_rd_i != 5'd0);
    ld_ready  = !rst_i && (count_q < CW'(DEPTH));
    // rd==0 loads complete the handshake but never occupy a slot.
    push      = bus.ld_valid_i && ld_ready && (bus.ld_rd_i != 5'd0);
    // The ALU owns the port; the FIFO only drains in ALU-idle cycles.
    pop       = !alu_wr && (count_q != '0);
    push_live = !(alu_wr && (bus.alu_rd_i == bus.ld_rd_i));
  end

  // FIFO storage, pointers, occupancy and the registered write port.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      live_q  <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      rs_q    <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
    end else begin
      // WAW kill of queued entries; the push below overrides its own slot.
      for (int i = 0; i < DEPTH; i++) begin
        if (alu_wr && (rd_q[i] == bus.alu_rd_i)) live_q[i] <= 1'b0;
      end
      if (push) begin
        rd_q[wptr_q]   <= bus.ld_rd_i;
        data_q[wptr_q] <= bus.ld_data_i;
        live_q[wptr_q] <= push_live;
        wptr_q         <= wptr_q + PW'(1);
      end
      if (pop) begin
        live_q[rptr_q] <= 1'b0;
        rptr_q         <= rptr_q + PW'(1);
      end
      count_q <= count_q + CW'(push) - CW'(pop);

      if (alu_wr) begin
        rs_q    <= bus.alu_rd_i;
        wdata_q <= bus.alu_data_i;
        we_q    <= 1'b1;
      end else if (pop) begin
        rs_q    <= rd_q[rptr_q];
        wdata_q <= data_q[rptr_q];
        we_q    <= live_q[rptr_q];
      end else begin
        we_q    <= 1'b0;
      end
    end
  end

  // Pending-write mask: live is only ever set on an occupied slot, so it alone
  // identifies queued loads that will still write.
  always_comb begin
    mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live_q[i]) mask[rd_q[i]] = 1'b1;
    end
    mask[0] = 1'b0;
  end

  assign bus.ld_ready_o     = ld_ready;
  assign bus.rsW_o          = rs_q;
  assign bus.dataW_o        = wdata_q;
  assign bus.RegWEn_o       = we_q;
  assign bus.pending_mask_o = mask;
  assign bus.count_o        = count_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: inputs change 1ns after a rising edge and the
// registered outputs are checked at that same point, i.e. they show the result
// of the inputs applied during the previous cycle.
module tb_wb_arbiter;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   total = 0;
  int   bad   = 0;

  wb_arbiter_if #(.DEPTH(4)) bus ();

  wb_arbiter #(.DEPTH(4)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  // Clock and watchdog
  always #5 clk_i = ~clk_i;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    bus.alu_valid_i = 1'b0;
    bus.alu_rd_i    = 5'd0;
    bus.alu_data_i  = 32'd0;
    bus.ld_valid_i  = 1'b0;
    bus.ld_rd_i     = 5'd0;
    bus.ld_data_i   = 32'd0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    idle_inputs();
    step();
    step();
    total++; if (bus.RegWEn_o !== 1'b0) begin bad++; $display("FAIL reset_we got=%b exp=0", bus.RegWEn_o); end
    total++; if (bus.rsW_o !== 5'd0) begin bad++; $display("FAIL reset_rs got=%0d exp=0", bus.rsW_o); end
    total++; if (bus.dataW_o !== 32'd0) begin bad++; $display("FAIL reset_data got=%h exp=0", bus.dataW_o); end
    total++; if (bus.count_o !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", bus.count_o); end
    total++; if (bus.pending_mask_o !== 32'd0) begin bad++; $display("FAIL reset_mask got=%h exp=0", bus.pending_mask_o); end
    total++; if (bus.ld_ready_o !== 1'b0) begin bad++; $display("FAIL reset_ready_in_rst got=%b exp=0", bus.ld_ready_o); end
    rst_i = 1'b0;
    #1;
    total++; if (bus.ld_ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready_after got=%b exp=1", bus.ld_ready_o); end
  endtask

  task automatic test_alu();
    bus.alu_valid_i = 1'b1; bus.alu_rd_i = 5'd5; bus.alu_data_i = 32'hDEADBEEF;
    step();
    idle_inputs();
    total++; if (bus.RegWEn_o !== 1'b1) begin bad++; $display("FAIL alu_we got=%b exp=1", bus.RegWEn_o); end
    total++; if (bus.rsW_o !== 5'd5) begin bad++; $display("FAIL alu_rs got=%0d exp=5", bus.rsW_o); end
    total++; if (bus.dataW_o !== 32'hDEADBEEF) begin bad++; $display("FAIL alu_data got=%h exp=deadbeef", bus.dataW_o); end
    step();
    total++; if (bus.RegWEn_o !== 1'b0) begin bad++; $display("FAIL alu_we_drop got=%b exp=0", bus.RegWEn_o); end
    total++; if (bus.rsW_o !== 5'd5) begin bad++; $display("FAIL alu_rs_hold got=%0d exp=5", bus.rsW_o); end
  endtask

  task automatic test_single_load();
    bus.ld_valid_i = 1'b1; bus.ld_rd_i = 5'd7; bus.ld_data_i = 32'h12345678;
    total++; if (bus.ld_ready_o !== 1'b1) begin bad++; $display("FAIL ld_ready got=%b exp=1", bus.ld_ready_o); end
    step();
    idle_inputs();
    total++; if (bus.pending_mask_o !== 32'h80) begin bad++; $display("FAIL ld_mask got=%h exp=80", bus.pending_mask_o); end
    total++; if (bus.count_o !== 3'd1) begin bad++; $display("FAIL ld_count got=%0d exp=1", bus.count_o); end
    total++; if (bus.RegWEn_o !== 1'b0) begin bad++; $display("FAIL ld_we_early got=%b exp=0", bus.RegWEn_o); end
    step();
    total++; if (bus.RegWEn_o !== 1'b1) begin bad++; $display("FAIL ld_we got=%b exp=1", bus.RegWEn_o); end
    total++; if (bus.rsW_o !== 5'd7) begin bad++; $display("FAIL ld_rs got=%0d exp=7", bus.rsW_o); end
    total++; if (bus.dataW_o !== 32'h12345678) begin bad++; $display("FAIL ld_data got=%h exp=12345678", bus.dataW_o); end
    total++; if (bus.pending_mask_o !== 32'd0) begin bad++; $display("FAIL ld_mask_clear got=%h exp=0", bus.pending_mask_o); end
    total++; if (bus.count_o !== 3'd0) begin bad++; $display("FAIL ld_count_drain got=%0d exp=0", bus.count_o); end
    step();
    total++; if (bus.RegWEn_o !== 1'b0) begin bad++; $display("FAIL ld_we_after got=%b exp=0", bus.RegWEn_o); end
  endtask

  task automatic test_fill();
    bus.alu_valid_i = 1'b1; bus.alu_rd_i = 5'd1;
    for (int i = 0; i < 5; i++) begin
      bus.alu_data_i = 32'hA000 + i;
      bus.ld_valid_i = 1'b1;
      bus.ld_rd_i    = 5'(10 + i);
      bus.ld_data_i  = 32'h100 + i;
      #1;
      total++; if (bus.ld_ready_o !== (i < 4)) begin bad++; $display("FAIL fill_ready[%0d] got=%b exp=%b", i, bus.ld_ready_o, (i < 4)); end
      step();
      total++; if (bus.RegWEn_o !== 1'b1 || bus.rsW_o !== 5'd1 || bus.dataW_o !== 32'hA000 + i) begin
        bad++; $display("FAIL fill_alu[%0d] got=%b/%0d/%h exp=1/1/%h", i, bus.RegWEn_o, bus.rsW_o, bus.dataW_o, 32'hA000 + i);
      end
    end
    idle_inputs();
    total++; if (bus.count_o !== 3'd4) begin bad++; $display("FAIL fill_count got=%0d exp=4", bus.count_o); end
    total++; if (bus.ld_ready_o !== 1'b0) begin bad++; $display("FAIL fill_full_ready got=%b exp=0", bus.ld_ready_o); end
    total++; if (bus.pending_mask_o !== 32'h3C00) begin bad++; $display("FAIL fill_mask got=%h exp=3c00", bus.pending_mask_o); end
    for (int i = 0; i < 4; i++) begin
      step();
      total++; if (bus.RegWEn_o !== 1'b1 || bus.rsW_o !== 5'(10 + i) || bus.dataW_o !== 32'h100 + i) begin
        bad++; $display("FAIL drain[%0d] got=%b/%0d/%h exp=1/%0d/%h", i, bus.RegWEn_o, bus.rsW_o, bus.dataW_o, 10 + i, 32'h100 + i);
      end
    end
    total++; if (bus.count_o !== 3'd0 || bus.ld_ready_o !== 1'b1) begin bad++; $display("FAIL drain_end got=%0d/%b exp=0/1", bus.count_o, bus.ld_ready_o); end
    step();
    total++; if (bus.RegWEn_o !== 1'b0) begin bad++; $display("FAIL drain_idle got=%b exp=0", bus.RegWEn_o); end
  endtask

  task automatic test_waw();
    bus.alu_valid_i = 1'b1; bus.alu_rd_i = 5'd2; bus.alu_data_i = 32'h22;
    bus.ld_valid_i = 1'b1; bus.ld_rd_i = 5'd9; bus.ld_data_i = 32'hAAAA;
    step();
    total++; if (bus.pending_mask_o !== 32'h200) begin bad++; $display("FAIL waw_mask_set got=%h exp=200", bus.pending_mask_o); end
    bus.ld_valid_i = 1'b0;
    bus.alu_rd_i = 5'd9; bus.alu_data_i = 32'h5555;
    step();
    idle_inputs();
    total++; if (bus.RegWEn_o !== 1'b1 || bus.rsW_o !== 5'd9 || bus.dataW_o !== 32'h5555) begin
      bad++; $display("FAIL waw_alu got=%b/%0d/%h exp=1/9/5555", bus.RegWEn_o, bus.rsW_o, bus.dataW_o);
    end
    total++; if (bus.pending_mask_o !== 32'd0) begin bad++; $display("FAIL waw_mask_clear got=%h exp=0", bus.pending_mask_o); end
    total++; if (bus.count_o !== 3'd1) begin bad++; $display("FAIL waw_count got=%0d exp=1", bus.count_o); end
    step();
    total++; if (bus.RegWEn_o !== 1'b0) begin bad++; $display("FAIL waw_killed_pop got=%b exp=0", bus.RegWEn_o); end
    total++; if (bus.count_o !== 3'd0) begin bad++; $display("FAIL waw_count_drain got=%0d exp=0", bus.count_o); end
    // Same-cycle kill of a load being enqueued.
    bus.alu_valid_i = 1'b1; bus.alu_rd_i = 5'd12; bus.alu_data_i = 32'hC0DE;
    bus.ld_valid_i = 1'b1; bus.ld_rd_i = 5'd12; bus.ld_data_i = 32'hBAD0;
    step();
    idle_inputs();
    total++; if (bus.count_o !== 3'd1 || bus.pending_mask_o !== 32'd0) begin
      bad++; $display("FAIL waw_same_cycle got=%0d/%h exp=1/0", bus.count_o, bus.pending_mask_o);
    end
    total++; if (bus.RegWEn_o !== 1'b1 || bus.dataW_o !== 32'hC0DE) begin bad++; $display("FAIL waw_same_alu got=%b/%h exp=1/c0de", bus.RegWEn_o, bus.dataW_o); end
    step();
    total++; if (bus.RegWEn_o !== 1'b0 || bus.count_o !== 3'd0) begin bad++; $display("FAIL waw_same_pop got=%b/%0d exp=0/0", bus.RegWEn_o, bus.count_o); end
  endtask

  task automatic test_x0();
    bus.alu_valid_i = 1'b1; bus.alu_rd_i = 5'd0; bus.alu_data_i = 32'hFFFF_FFFF;
    bus.ld_valid_i = 1'b1; bus.ld_rd_i = 5'd0; bus.ld_data_i = 32'h1111;
    #1;
    total++; if (bus.ld_ready_o !== 1'b1) begin bad++; $display("FAIL x0_ready got=%b exp=1", bus.ld_ready_o); end
    step();
    idle_inputs();
    total++; if (bus.RegWEn_o !== 1'b0) begin bad++; $display("FAIL x0_we got=%b exp=0", bus.RegWEn_o); end
    total++; if (bus.count_o !== 3'd0 || bus.pending_mask_o !== 32'd0) begin bad++; $display("FAIL x0_queue got=%0d/%h exp=0/0", bus.count_o, bus.pending_mask_o); end
    step();
    total++; if (bus.RegWEn_o !== 1'b0) begin bad++; $display("FAIL x0_we_late got=%b exp=0", bus.RegWEn_o); end
  endtask

  task automatic test_reset_mid();
    bus.alu_valid_i = 1'b1; bus.alu_rd_i = 5'd3; bus.alu_data_i = 32'h33;
    for (int i = 0; i < 3; i++) begin
      bus.ld_valid_i = 1'b1; bus.ld_rd_i = 5'(20 + i); bus.ld_data_i = 32'h2000 + i;
      step();
    end
    idle_inputs();
    total++; if (bus.count_o !== 3'd3 || bus.pending_mask_o !== 32'h0070_0000) begin
      bad++; $display("FAIL rstmid_pre got=%0d/%h exp=3/00700000", bus.count_o, bus.pending_mask_o);
    end
    rst_i = 1'b1;
    step();
    total++; if (bus.count_o !== 3'd0 || bus.pending_mask_o !== 32'd0 || bus.RegWEn_o !== 1'b0) begin
      bad++; $display("FAIL rstmid_state got=%0d/%h/%b exp=0/0/0", bus.count_o, bus.pending_mask_o, bus.RegWEn_o);
    end
    rst_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      total++; if (bus.RegWEn_o !== 1'b0 || bus.count_o !== 3'd0) begin
        bad++; $display("FAIL rstmid_nowrite[%0d] got=%b/%0d exp=0/0", i, bus.RegWEn_o, bus.count_o);
      end
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_alu();
    test_single_load();
    test_fill();
    test_waw();
    test_x0();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Write-back arbiter on the producer side of the register file's single write port.
- Merges two result streams into one registered write port (rsW_o/dataW_o/RegWEn_o) that drives the register file's rsW_i/dataW_i/RegWEn_i:
  - single-cycle ALU results;
  - variable-latency load returns.
- Load returns are buffered in a small FIFO.
- Provides a pending-write mask for the decode hazard logic.

Parameters:
- DEPTH, 4, load FIFO entries; power of two, >= 2.

Ports:
- clk_i  input  1  clock, all state updates on rising edge.
- rst_i  input  1  synchronous reset, active-high.
- alu_valid_i  input  1  ALU result valid this cycle; no backpressure, always accepted.
- alu_rd_i  input  5  ALU destination register.
- alu_data_i  input  32  ALU result.
- ld_valid_i  input  1  load return valid.
- ld_ready_o  output  1  FIFO can accept a load; a transfer occurs when ld_valid_i && ld_ready_o.
- ld_rd_i  input  5  load destination register.
- ld_data_i  input  32  load data.
- rsW_o  output  5  write address to register file.
- dataW_o  output  32  write data to register file.
- RegWEn_o  output  1  write enable to register file.
- pending_mask_o  output  32  bit r set when a live (unkilled) queued load targets xr; bit 0 always 0.
- count_o  output  $clog2(DEPTH)+1  FIFO occupancy, killed entries included.

Behaviour:
- Reset (rst_i high at a clock edge):
  - rsW_o=0, dataW_o=0, RegWEn_o=0, count_o=0, pending_mask_o=0.
  - All FIFO entries are invalidated.
  - ld_ready_o=0 while rst_i is high.
  - Reset mid-operation discards queued loads without writing them.
- ld_ready_o = !rst_i && (count_o < DEPTH). It is combinational from registered state. There is no pass-through when full, even if a pop occurs in the same cycle.
- rd==0 filtering:
  - An ALU write with alu_rd_i==0 is dropped.
  - A load with ld_rd_i==0 is accepted (handshake completes) but not enqueued.
- Per-cycle selection (output register loaded every cycle):
  - Rule 1: if alu_valid_i && alu_rd_i!=0, the output takes {alu_rd_i, alu_data_i} with RegWEn_o=1 next cycle, and the FIFO does not pop.
  - Rule 2: else if the FIFO is non-empty, the head pops. The output takes the head's {rd, data} with RegWEn_o = head.live.
  - Rule 3: else RegWEn_o=0 next cycle. rsW_o and dataW_o hold their previous values.
- Latency:
  - ALU: 1 cycle from input to RegWEn_o.
  - Load into an empty FIFO with no ALU traffic: accepted in cycle N, enqueued at edge N+1, popped in cycle N+1, RegWEn_o high in cycle N+2.
- WAW kill rule: an ALU write (valid, rd!=0) clears the live bit of every queued entry whose rd matches. This includes a load being enqueued in the same cycle with the same rd. ALU results always supersede buffered loads.
- Killed entries:
  - They still occupy a slot and drain in order.
  - Popping one produces RegWEn_o=0 and counts as a pop.
- Push and pop in the same cycle: count_o is unchanged. Read and write pointers wrap modulo DEPTH.
- pending_mask_o:
  - It is the OR of one-hot(rd) over live valid entries, computed from registered state.
  - A load in the output register (being written) is not included.
- Starvation: continuous ALU traffic starves the FIFO by design. Upstream throttles loads via ld_ready_o.

Test Plan:
- ALU only: alu_valid_i=1, rd=5, data=0xDEADBEEF at cycle 3 -> RegWEn_o=1, rsW_o=5, dataW_o=0xDEADBEEF in cycle 4; RegWEn_o=0 in cycle 5.
- Single load with the bus idle: ld rd=7, data=0x12345678 accepted at cycle 2 -> pending_mask_o=0x80 in cycle 3; write of rd 7 in cycle 4; mask returns to 0.
- Fill and backpressure:
  - Hold alu_valid_i=1 (rd=1) while issuing 5 loads -> 4 accepted, count_o=4, ld_ready_o=0.
  - Drop ALU traffic -> 4 writes on consecutive cycles in FIFO order, then ld_ready_o=1.
- WAW kill:
  - Queue a load rd=9, data=0xAAAA behind ALU traffic; then ALU writes rd=9, data=0x5555.
  - Required: the rd 9 write of 0x5555 occurs; the later pop of 0xAAAA has RegWEn_o=0; pending_mask_o bit 9 clears the cycle after the ALU write.
- x0 handling: ALU rd=0 and load rd=0 -> no RegWEn_o assertion, count_o stays 0, handshake still completes (ld_ready_o=1).
- Reset mid-operation: with 3 entries queued, pulse rst_i for one cycle -> next cycle count_o=0, pending_mask_o=0, RegWEn_o=0; no queued data is ever written.
